// File: rtl/rx_frame.sv
// rx_frame: strips preamble/SFD, checks FCS, length and rxer, streams payload.
// Define RX_FRAME_STATS_EN to build the good_cnt/bad_cnt frame counters.
module rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        rxclk,
    input  logic        rst_n,
    input  logic        rxdv,
    input  logic        rxer,
    input  logic [7:0]  rxbyte,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pl_sof,
    output logic        pl_eof,
    output logic        frame_ok,
    output logic        frame_bad,
    output logic        crc_err,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;
    localparam logic [10:0] LEN_MIN     = 11'(MIN_LEN);
    localparam logic [10:0] LEN_MAX     = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT     = 11'h7FF;
    localparam logic [10:0] LEN_FCS     = 11'd4;

    logic [1:0]      state_q, state_d;
    logic [2:0]      pre_cnt_q, pre_cnt_d;
    logic [31:0]     crc_q, crc_d;
    logic [10:0]     len_q, len_d;
    logic [3:0][7:0] dly_q, dly_d;
    logic            err_q, err_d;
    logic            dv_q, dv_d;
    logic [7:0]      pl_data_q, pl_data_d;
    logic            pl_valid_q, pl_valid_d;
    logic            pl_sof_q, pl_sof_d;
    logic            pl_eof_q, pl_eof_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_bad_q, frame_bad_d;
    logic            crc_err_q, crc_err_d;
    logic            crc_good;
    logic            len_good;
    logic            verdict_good;

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_good     = (crc_q == CRC_RESIDUE);
    assign len_good     = (len_q >= LEN_MIN) && (len_q <= LEN_MAX);
    assign verdict_good = crc_good && len_good && !err_q;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        crc_d       = crc_q;
        len_d       = len_q;
        dly_d       = dly_q;
        err_d       = err_q;
        dv_d        = rxdv;
        pl_data_d   = 8'h00;
        pl_valid_d  = 1'b0;
        pl_sof_d    = 1'b0;
        pl_eof_d    = 1'b0;
        frame_ok_d  = 1'b0;
        frame_bad_d = 1'b0;
        crc_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // dv_q high here means we joined a frame already in flight
                if (rxdv) begin
                    if (!dv_q && rxbyte == 8'h55) begin
                        state_d   = S_PRE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_PRE: begin
                if (!rxdv) begin
                    state_d = S_IDLE;
                end else if (rxbyte == 8'h55) begin
                    if (pre_cnt_q == 3'd7) state_d = S_DROP;
                    else pre_cnt_d = pre_cnt_q + 3'd1;
                end else if (rxbyte == 8'hD5) begin
                    state_d = S_DATA;
                    crc_d   = 32'hFFFFFFFF;
                    len_d   = 11'd0;
                    err_d   = 1'b0;
                    dly_d   = '0;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_DATA: begin
                if (rxdv) begin
                    crc_d = crc_step(crc_q, rxbyte);
                    len_d = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
                    dly_d = {dly_q[2:0], rxbyte};
                    if (rxer || len_q >= LEN_MAX) err_d = 1'b1;
                    // oldest delay slot is 4 bytes behind, so FCS never leaves
                    if (len_q >= LEN_FCS && len_q < LEN_MAX) begin
                        pl_valid_d = 1'b1;
                        pl_data_d  = dly_q[3];
                        pl_sof_d   = (len_q == LEN_FCS);
                    end
                end else begin
                    state_d     = S_IDLE;
                    pl_eof_d    = 1'b1;
                    frame_ok_d  = verdict_good;
                    frame_bad_d = !verdict_good;
                    crc_err_d   = !crc_good;
                end
            end
            default: begin
                if (!rxdv) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= 3'd0;
            crc_q       <= 32'd0;
            len_q       <= 11'd0;
            dly_q       <= '0;
            err_q       <= 1'b0;
            dv_q        <= 1'b1;
            pl_data_q   <= 8'h00;
            pl_valid_q  <= 1'b0;
            pl_sof_q    <= 1'b0;
            pl_eof_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_bad_q <= 1'b0;
            crc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            dly_q       <= dly_d;
            err_q       <= err_d;
            dv_q        <= dv_d;
            pl_data_q   <= pl_data_d;
            pl_valid_q  <= pl_valid_d;
            pl_sof_q    <= pl_sof_d;
            pl_eof_q    <= pl_eof_d;
            frame_ok_q  <= frame_ok_d;
            frame_bad_q <= frame_bad_d;
            crc_err_q   <= crc_err_d;
        end
    end

    assign pl_data   = pl_data_q;
    assign pl_valid  = pl_valid_q;
    assign pl_sof    = pl_sof_q;
    assign pl_eof    = pl_eof_q;
    assign frame_ok  = frame_ok_q;
    assign frame_bad = frame_bad_q;
    assign crc_err   = crc_err_q;

`ifdef RX_FRAME_STATS_EN
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] bad_cnt_q, bad_cnt_d;

    always_comb begin
        good_cnt_d = good_cnt_q + {15'd0, frame_ok_d};
        bad_cnt_d  = bad_cnt_q + {15'd0, frame_bad_d};
    end

    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_q <= 16'd0;
            bad_cnt_q  <= 16'd0;
        end else begin
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign good_cnt = good_cnt_q;
    assign bad_cnt  = bad_cnt_q;
`else
    assign good_cnt = 16'd0;
    assign bad_cnt  = 16'd0;
`endif

endmodule
